// File: rtl/compound_sink_if.sv
// Stream, preset and result signals between the producer stage and compound_sink.
// compound_pkg defines the CompoundType transaction carried on the stream and preset ports.
package compound_pkg;
  typedef enum logic {
    MODE_WRITE = 1'b0,
    MODE_READ  = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic signed [31:0] y;
  } compound_t;
endpackage

interface compound_sink_if #(
  parameter int DEPTH = 4
) ();
  import compound_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);

  compound_t          b_in;
  logic               b_in_sync;
  logic               b_in_notify;
  compound_t          m_in;
  logic               m_in_sync;
  logic signed [31:0] res_out;
  logic               res_out_notify;
  logic               res_out_sync;
  logic [LW-1:0]      level_out;

  modport slave (
    input  b_in, b_in_sync, m_in, m_in_sync, res_out_sync,
    output b_in_notify, res_out, res_out_notify, level_out
  );

  modport master (
    output b_in, b_in_sync, m_in, m_in_sync, res_out_sync,
    input  b_in_notify, res_out, res_out_notify, level_out
  );
endinterface

// File: rtl/compound_sink.sv
// Buffers CompoundType stream entries in a FIFO; writes accumulate x, reads emit the accumulator.
// Optional macro COMPOUND_SINK_SAT_EN makes accumulation saturate instead of wrapping.
module compound_sink
  import compound_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  compound_sink_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      count_q, count_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] res_q, res_d;
  logic               clr_q, clr_d;
  logic               notify_q, notify_d;
  compound_t          mem_q [DEPTH];

  logic               full;
  logic               push;
  logic               pop;
  logic               preset;
  compound_t          head;
  logic signed [31:0] acc_base;
  logic               unused_m_in_y;

  function automatic logic signed [31:0] acc_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
`ifdef COMPOUND_SINK_SAT_EN
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    // Sign bits disagreeing means the true sum left the 32-bit range.
    if (s[32] != s[31]) begin
      return s[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  assign full           = (count_q == LW'(DEPTH));
  assign push           = bus.b_in_sync && !full;
  assign unused_m_in_y  = ^bus.m_in.y;

  assign bus.b_in_notify    = !full;
  assign bus.res_out        = res_q;
  assign bus.res_out_notify = notify_q;
  assign bus.level_out      = count_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    res_d    = res_q;
    clr_d    = clr_q;
    notify_d = notify_q;
    pop      = 1'b0;
    head     = mem_q[rd_ptr_q];
    preset   = bus.m_in_sync && (bus.m_in.mode == MODE_WRITE);
    // A preset in IDLE replaces the accumulator before any popped entry is applied.
    acc_base = preset ? bus.m_in.x : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head.mode == MODE_WRITE) begin
            acc_d = acc_add(acc_base, head.x);
          end else begin
            res_d    = acc_base;
            acc_d    = acc_base;
            clr_d    = (head.y != 32'sd0);
            notify_d = 1'b1;
            state_d  = ST_EMIT;
          end
        end else if (preset) begin
          acc_d = bus.m_in.x;
        end
      end
      ST_EMIT: begin
        if (bus.res_out_sync) begin
          notify_d = 1'b0;
          if (clr_q) begin
            acc_d = '0;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      clr_q    <= 1'b0;
      notify_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      clr_q    <= clr_d;
      notify_q <= notify_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= bus.b_in;
    end
  end
endmodule

// File: tb/tb_compound_sink.sv
// Directed scoreboard bench for compound_sink: expected results are queued at issue and
// checked by a monitor at each result handshake.
module tb_compound_sink;
  import compound_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  compound_sink_if #(.DEPTH(4)) bus ();

  compound_sink #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: %h ok", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input mode_e m, input logic [31:0] x, input logic [31:0] y);
    int   waited;
    logic took;
    waited = 0;
    took   = 1'b0;
    bus.b_in      = '{mode: m, x: x, y: y};
    bus.b_in_sync = 1'b1;
    while (!took && waited < 50) begin
      took = bus.b_in_notify;
      tick(1);
      waited++;
    end
    bus.b_in_sync = 1'b0;
    if (!took) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got no accept expected accept within 50 cycles");
    end else begin
      $display("push mode=%0d x=%h y=%h", m, x, y);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Monitor: a handshake completes at the next posedge when both flags are high now.
  always @(negedge clk) begin
    if (!rst && bus.res_out_notify && bus.res_out_sync) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL result_unexpected: got %h expected no result", bus.res_out);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        if (bus.res_out !== exp) begin
          n_bad++;
          $display("FAIL result: got %h expected %h", bus.res_out, exp);
        end else begin
          $display("result %h ok", bus.res_out);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ovf_pos;
    logic [31:0] ovf_neg;
`ifdef COMPOUND_SINK_SAT_EN
    ovf_pos = 32'h7fff_ffff;
    ovf_neg = 32'h8000_0000;
`else
    ovf_pos = 32'h8000_0000;
    ovf_neg = 32'h7fff_ffff;
`endif
    bus.b_in         = '{mode: MODE_WRITE, x: 32'sd0, y: 32'sd0};
    bus.b_in_sync    = 1'b0;
    bus.m_in         = '{mode: MODE_WRITE, x: 32'sd0, y: 32'sd0};
    bus.m_in_sync    = 1'b0;
    bus.res_out_sync = 1'b1;
    tick(2);
    rst = 1'b0;

    check("rst_b_in_notify", 32'(bus.b_in_notify), 32'd1);
    check("rst_res_out", bus.res_out, 32'd0);
    check("rst_res_notify", 32'(bus.res_out_notify), 32'd0);
    check("rst_level", 32'(bus.level_out), 32'd0);

    // Back-to-back write, write, read with the consumer always ready.
    push(MODE_WRITE, 32'd5, 32'd0);
    push(MODE_WRITE, 32'd7, 32'd0);
    sb.push_back(32'd12);
    push(MODE_READ, 32'd0, 32'd0);
    tick(1);
    check("emit_notify_high", 32'(bus.res_out_notify), 32'd1);
    tick(1);
    check("emit_one_cycle", 32'(bus.res_out_notify), 32'd0);
    check("level_drained", 32'(bus.level_out), 32'd0);
    sb.push_back(32'd12);
    push(MODE_READ, 32'd0, 32'd0);
    tick(3);

    // Stall the result port until the FIFO fills behind the pending read.
    do_reset();
    bus.res_out_sync = 1'b0;
    sb.push_back(32'd0);
    push(MODE_READ, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) push(MODE_WRITE, 32'd1, 32'd0);
    check("full_level", 32'(bus.level_out), 32'd4);
    check("full_notify", 32'(bus.b_in_notify), 32'd0);
    bus.b_in         = '{mode: MODE_WRITE, x: 32'sd100, y: 32'sd0};
    bus.b_in_sync    = 1'b1;
    bus.res_out_sync = 1'b1;
    tick(2);
    bus.b_in_sync    = 1'b0;
    check("full_push_refused_level", 32'(bus.level_out), 32'd3);
    tick(4);
    check("drain_level", 32'(bus.level_out), 32'd0);
    check("drain_notify", 32'(bus.b_in_notify), 32'd1);
    sb.push_back(32'd4);
    push(MODE_READ, 32'd0, 32'd1);

    // Clearing read after writes totalling 9, then a read of the cleared accumulator.
    push(MODE_WRITE, 32'd2, 32'd0);
    push(MODE_WRITE, 32'd3, 32'd0);
    push(MODE_WRITE, 32'd4, 32'd0);
    sb.push_back(32'd9);
    push(MODE_READ, 32'd0, 32'd1);
    sb.push_back(32'd0);
    push(MODE_READ, 32'd0, 32'd0);
    tick(4);

    // Preset alongside a popped write, then a preset while a result is pending.
    push(MODE_WRITE, 32'd3, 32'd0);
    bus.m_in      = '{mode: MODE_WRITE, x: 32'sd100, y: 32'sd0};
    bus.m_in_sync = 1'b1;
    tick(1);
    bus.m_in_sync = 1'b0;
    bus.res_out_sync = 1'b0;
    sb.push_back(32'd103);
    push(MODE_READ, 32'd0, 32'd0);
    tick(1);
    check("preset_emit_notify", 32'(bus.res_out_notify), 32'd1);
    bus.m_in      = '{mode: MODE_WRITE, x: 32'sd500, y: 32'sd0};
    bus.m_in_sync = 1'b1;
    tick(1);
    bus.m_in_sync = 1'b0;
    check("preset_emit_hold", bus.res_out, 32'd103);
    bus.res_out_sync = 1'b1;
    tick(2);
    sb.push_back(32'd103);
    push(MODE_READ, 32'd0, 32'd1);
    tick(3);

    // Overflow in both directions.
    push(MODE_WRITE, 32'h7fff_ffff, 32'd0);
    push(MODE_WRITE, 32'd1, 32'd0);
    sb.push_back(ovf_pos);
    push(MODE_READ, 32'd0, 32'd1);
    tick(3);
    push(MODE_WRITE, 32'h8000_0000, 32'd0);
    push(MODE_WRITE, 32'hffff_ffff, 32'd0);
    sb.push_back(ovf_neg);
    push(MODE_READ, 32'd0, 32'd1);
    tick(3);

    // Reset while a result is pending with two entries buffered.
    bus.res_out_sync = 1'b0;
    push(MODE_WRITE, 32'd9, 32'd0);
    push(MODE_READ, 32'd0, 32'd0);
    push(MODE_WRITE, 32'd1, 32'd0);
    push(MODE_WRITE, 32'd1, 32'd0);
    check("pre_rst_level", 32'(bus.level_out), 32'd2);
    check("pre_rst_notify", 32'(bus.res_out_notify), 32'd1);
    do_reset();
    check("mid_rst_notify", 32'(bus.res_out_notify), 32'd0);
    check("mid_rst_level", 32'(bus.level_out), 32'd0);
    check("mid_rst_b_in_notify", 32'(bus.b_in_notify), 32'd1);
    check("mid_rst_res_out", bus.res_out, 32'd0);
    bus.res_out_sync = 1'b1;
    sb.push_back(32'd0);
    push(MODE_READ, 32'd0, 32'd0);
    tick(4);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
